// File: rtl/zoom_scan_controller.sv
// Raster coordinate sweeper for the zoom path: walks the output window, pairs each
// 1-cycle-latency source pixel with its coordinate and writes it to the framebuffer.
module zoom_scan_controller #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120,
    parameter int FB_WIDTH      = 320,
    parameter int FB_HEIGHT     = 240
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  SHIFT_FACTOR,
    output logic [8:0]  X_OUT_COORD,
    output logic [7:0]  Y_OUT_COORD,
    output logic [1:0]  SHIFT_OUT,
    input  logic [7:0]  PIXEL_RD,
    output logic [16:0] W_ADDR,
    output logic [7:0]  W_DATA,
    output logic        W_EN,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [1:0]  shift_q, shift_d;
    logic [8:0]  act_w_q, act_w_d;
    logic [7:0]  act_h_q, act_h_d;
    logic        vld_q;
    logic [8:0]  wx_q;
    logic [7:0]  wy_q;

    // Zoomed size held at 12 bits so 160<<3 / 120<<3 do not wrap before clamping.
    logic [11:0] zoom_w, zoom_h;
    logic [8:0]  win_w;
    logic [7:0]  win_h;

    assign zoom_w = 12'(IMG_WIDTH_IN) << SHIFT_FACTOR;
    assign zoom_h = 12'(IMG_HEIGHT_IN) << SHIFT_FACTOR;
    assign win_w  = (zoom_w > 12'(FB_WIDTH))  ? 9'(FB_WIDTH)  : zoom_w[8:0];
    assign win_h  = (zoom_h > 12'(FB_HEIGHT)) ? 8'(FB_HEIGHT) : zoom_h[7:0];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        shift_d = shift_q;
        act_w_d = act_w_q;
        act_h_d = act_h_q;
        case (state_q)
            S_IDLE: begin
                x_d = 9'd0;
                y_d = 8'd0;
                if (START) begin
                    shift_d = SHIFT_FACTOR;
                    act_w_d = win_w;
                    act_h_d = win_h;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (x_q == act_w_q - 9'd1) begin
                    // Final coordinate stays on the outputs through DRAIN and FIN.
                    if (y_q == act_h_q - 8'd1) begin
                        state_d = S_DRAIN;
                    end else begin
                        x_d = 9'd0;
                        y_d = y_q + 8'd1;
                    end
                end else begin
                    x_d = x_q + 9'd1;
                end
            end
            S_DRAIN: state_d = S_FIN;
            S_FIN: begin
                x_d     = 9'd0;
                y_d     = 8'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            x_q     <= 9'd0;
            y_q     <= 8'd0;
            shift_q <= 2'd0;
            act_w_q <= 9'd0;
            act_h_q <= 8'd0;
            vld_q   <= 1'b0;
            wx_q    <= 9'd0;
            wy_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            shift_q <= shift_d;
            act_w_q <= act_w_d;
            act_h_q <= act_h_d;
            vld_q   <= (state_q == S_RUN);
            wx_q    <= x_q;
            wy_q    <= y_q;
        end
    end

    assign X_OUT_COORD = x_q;
    assign Y_OUT_COORD = y_q;
    assign SHIFT_OUT   = shift_q;
    assign W_EN        = vld_q;
    // Pixel arrives one cycle after its coordinate, aligned with the delayed coordinate.
    assign W_DATA      = vld_q ? PIXEL_RD : 8'd0;
    assign W_ADDR      = 17'(wy_q) * 17'(FB_WIDTH) + 17'(wx_q);
    assign BUSY        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign DONE        = (state_q == S_FIN);

endmodule

// File: tb/tb_zoom_scan_controller.sv
// Bench for zoom_scan_controller: a full-size instance and a reduced-size instance
// are swept against an expected-write queue built from the window/zoom rules.
module tb_zoom_scan_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Full-size instance
    logic        reset_b = 1'b1, start_b = 1'b0;
    logic [1:0]  shift_b = 2'd0;
    logic [7:0]  pix_b = 8'd0;
    logic [8:0]  x_b;
    logic [7:0]  y_b;
    logic [1:0]  sho_b;
    logic [16:0] waddr_b;
    logic [7:0]  wdata_b;
    logic        wen_b, busy_b, done_b;

    // Reduced-size instance: 20x15 source, 40x30 framebuffer
    logic        reset_s = 1'b1, start_s = 1'b0;
    logic [1:0]  shift_s = 2'd0;
    logic [7:0]  pix_s = 8'd0;
    logic [8:0]  x_s;
    logic [7:0]  y_s;
    logic [1:0]  sho_s;
    logic [16:0] waddr_s;
    logic [7:0]  wdata_s;
    logic        wen_s, busy_s, done_s;

    zoom_scan_controller u_big (
        .CLK(clk), .RESET(reset_b), .START(start_b), .SHIFT_FACTOR(shift_b),
        .X_OUT_COORD(x_b), .Y_OUT_COORD(y_b), .SHIFT_OUT(sho_b), .PIXEL_RD(pix_b),
        .W_ADDR(waddr_b), .W_DATA(wdata_b), .W_EN(wen_b), .BUSY(busy_b), .DONE(done_b)
    );

    zoom_scan_controller #(
        .IMG_WIDTH_IN(20), .IMG_HEIGHT_IN(15), .FB_WIDTH(40), .FB_HEIGHT(30)
    ) u_small (
        .CLK(clk), .RESET(reset_s), .START(start_s), .SHIFT_FACTOR(shift_s),
        .X_OUT_COORD(x_s), .Y_OUT_COORD(y_s), .SHIFT_OUT(sho_s), .PIXEL_RD(pix_s),
        .W_ADDR(waddr_s), .W_DATA(wdata_s), .W_EN(wen_s), .BUSY(busy_s), .DONE(done_s)
    );

    function automatic logic [7:0] mem_val(int a);
        return a[7:0];
    endfunction

    // Replicator + source RAM: 1-cycle registered read at the zoomed-down address.
    always @(posedge clk) begin
        pix_b <= mem_val(int'(y_b >> sho_b) * 160 + int'(x_b >> sho_b));
        pix_s <= mem_val(int'(y_s >> sho_s) * 20 + int'(x_s >> sho_s));
    end

    // Monitor mux onto the instance under test
    int          sel = 0;
    logic [8:0]  m_x;
    logic [7:0]  m_y;
    logic [1:0]  m_sho;
    logic [16:0] m_waddr;
    logic [7:0]  m_wdata;
    logic        m_wen, m_busy, m_done;

    always_comb begin
        m_x     = (sel != 0) ? x_s     : x_b;
        m_y     = (sel != 0) ? y_s     : y_b;
        m_sho   = (sel != 0) ? sho_s   : sho_b;
        m_waddr = (sel != 0) ? waddr_s : waddr_b;
        m_wdata = (sel != 0) ? wdata_s : wdata_b;
        m_wen   = (sel != 0) ? wen_s   : wen_b;
        m_busy  = (sel != 0) ? busy_s  : busy_b;
        m_done  = (sel != 0) ? done_s  : done_b;
    end

    function automatic int iw();  return (sel != 0) ? 20 : 160; endfunction
    function automatic int ih();  return (sel != 0) ? 15 : 120; endfunction
    function automatic int fbw(); return (sel != 0) ? 40 : 320; endfunction
    function automatic int fbh(); return (sel != 0) ? 30 : 240; endfunction
    function automatic int min2(int a, int b); return (a < b) ? a : b; endfunction

    task automatic set_start(logic v);
        if (sel != 0) start_s = v; else start_b = v;
    endtask
    task automatic set_shift(int v);
        if (sel != 0) shift_s = 2'(v); else shift_b = 2'(v);
    endtask
    task automatic set_reset(logic v);
        if (sel != 0) reset_s = v; else reset_b = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_wen"},   int'(m_wen), 0);
        check({tag, "_busy"},  int'(m_busy), 0);
        check({tag, "_done"},  int'(m_done), 0);
        check({tag, "_x"},     int'(m_x), 0);
        check({tag, "_y"},     int'(m_y), 0);
    endtask

    // Hand-picked coordinates with expected address/data worked out by hand.
    typedef struct {
        int sel; int s; int x; int y; int addr; int data;
    } spot_t;
    spot_t spots[9];

    // Expected writes: {x[8:0], y[7:0], addr[16:0], data[7:0]}
    logic [41:0] exp_q[$];

    task automatic run_sweep(int s, bit tog, bit chain, int next_s, int abort_after,
                             int exp_count, int exp_last);
        int aw, ah, n, c, wcount, first_c, last_c, done_c, last_addr;
        int busy_err, coord_err, shift_err, stray, ex, ey;
        logic [41:0] e;
        aw = min2(iw() << s, fbw());
        ah = min2(ih() << s, fbh());
        n  = aw * ah;
        exp_q.delete();
        for (int yy = 0; yy < ah; yy++)
            for (int xx = 0; xx < aw; xx++)
                exp_q.push_back({9'(xx), 8'(yy), 17'(yy * fbw() + xx),
                                 mem_val((yy >> s) * iw() + (xx >> s))});
        set_shift(s);
        set_start(1'b1);
        step();
        set_start(1'b0);
        c = 1; wcount = 0; first_c = -1; last_c = -1; done_c = -1; last_addr = -1;
        busy_err = 0; coord_err = 0; shift_err = 0;
        while (c <= n + 10) begin
            if (m_wen) begin
                wcount++;
                if (first_c < 0) first_c = c;
                last_c = c;
                last_addr = int'(m_waddr);
                if (exp_q.size() == 0) begin
                    check("extra_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("w_addr", int'(m_waddr), int'(e[24:8]));
                    check("w_data", int'(m_wdata), int'(e[7:0]));
                    foreach (spots[k])
                        if (spots[k].sel == sel && spots[k].s == s &&
                            spots[k].x == int'(e[41:33]) && spots[k].y == int'(e[32:25])) begin
                            check("spot_addr", int'(m_waddr), spots[k].addr);
                            check("spot_data", int'(m_wdata), spots[k].data);
                        end
                end
            end
            if (int'(m_busy) != ((c <= n + 1) ? 1 : 0)) busy_err++;
            ex = (c <= n) ? (c - 1) % aw : aw - 1;
            ey = (c <= n) ? (c - 1) / aw : ah - 1;
            if (int'(m_x) != ex || int'(m_y) != ey) coord_err++;
            if (int'(m_sho) != s) shift_err++;
            if (m_done) begin
                done_c = c;
                break;
            end
            if (abort_after > 0 && wcount == abort_after) begin
                set_start(1'b0);
                set_reset(1'b1);
                step();
                check_quiet("rst");
                check("rst_shift", int'(m_sho), 0);
                check("rst_waddr", int'(m_waddr), 0);
                check("rst_wdata", int'(m_wdata), 0);
                set_reset(1'b0);
                stray = 0;
                for (int i = 0; i < 6; i++) begin
                    step();
                    if (m_wen || m_done || m_busy) stray++;
                end
                check("post_rst_activity", stray, 0);
                return;
            end
            if (tog) begin
                set_start(1'($urandom_range(0, 1)));
                set_shift(int'($urandom_range(0, 3)));
            end
            step();
            c++;
        end
        check("done_seen", (done_c > 0) ? 1 : 0, 1);
        // START in the FIN cycle must be ignored; IDLE follows regardless.
        set_start(chain);
        set_shift(chain ? next_s : 0);
        step();
        check_quiet("idle_after_fin");
        if (!chain) set_start(1'b0);
        check("write_count", wcount, exp_count);
        check("queue_left", exp_q.size(), 0);
        check("first_wen_cycle", first_c, 2);
        check("last_wen_cycle", last_c, n + 1);
        check("done_cycle", done_c, n + 2);
        check("last_addr", last_addr, exp_last);
        check("busy_profile", busy_err, 0);
        check("coord_profile", coord_err, 0);
        check("shift_out_const", shift_err, 0);
    endtask

    typedef struct {
        int sel; int s; bit tog; bit chain; int next_s; int abort; int count; int last;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int s_cur, s_nxt, aw, ah;
        bit ch, tg;

        spots[0] = '{0, 0,   0,   0,     0,   0};
        spots[1] = '{0, 0, 159,   0,   159, 159};
        spots[2] = '{0, 0,   0,   1,   320, 160};
        spots[3] = '{0, 0, 159, 119, 38239, 255};
        spots[4] = '{0, 1,   3,   5,  1603,  65};
        spots[5] = '{1, 2,  39,  29,  1199, 149};
        spots[6] = '{1, 3,  39,  29,  1199,  64};
        spots[7] = '{1, 1,  39,  29,  1199,  43};
        spots[8] = '{1, 0,  19,  14,   579,  43};

        //           sel s tog chain nxt abort count  last
        vecs[0] = '{0, 0, 0, 0, 0,    0, 19200, 38239};
        vecs[1] = '{0, 1, 0, 0, 0, 2000,     0,     0};
        vecs[2] = '{0, 0, 1, 0, 0,    0, 19200, 38239};
        vecs[3] = '{1, 2, 0, 0, 0,    0,  1200,  1199};
        vecs[4] = '{1, 3, 1, 1, 0,    0,  1200,  1199};
        vecs[5] = '{1, 0, 0, 0, 0,    0,   300,   579};
        vecs[6] = '{1, 1, 1, 0, 0,  500,     0,     0};
        vecs[7] = '{1, 1, 0, 1, 3,    0,  1200,  1199};
        vecs[8] = '{1, 3, 0, 0, 0,    0,  1200,  1199};

        reset_b = 1'b1;
        reset_s = 1'b1;
        step();
        step();
        sel = 0;
        #1;
        check_quiet("reset_big");
        check("reset_big_waddr", int'(m_waddr), 0);
        sel = 1;
        #1;
        check_quiet("reset_small");
        check("reset_small_shift", int'(m_sho), 0);
        reset_b = 1'b0;
        reset_s = 1'b0;
        step();

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            #1;
            run_sweep(vecs[i].s, vecs[i].tog, vecs[i].chain, vecs[i].next_s,
                      vecs[i].abort, vecs[i].count, vecs[i].last);
        end

        // Random sweeps on the reduced instance, counts from the window rules.
        sel = 1;
        s_cur = int'($urandom_range(0, 3));
        for (int r = 0; r < 6; r++) begin
            tg    = 1'($urandom_range(0, 1));
            ch    = (r < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_nxt = int'($urandom_range(0, 3));
            aw = min2(20 << s_cur, 40);
            ah = min2(15 << s_cur, 30);
            run_sweep(s_cur, tg, ch, s_nxt, 0, aw * ah, (ah - 1) * 40 + aw - 1);
            s_cur = s_nxt;
            if (!ch) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
